// File: rtl/sfx_stream_player.sv
// Multi-slot sound-effect sequencer: ROM fetch per tick, per-slot volume, priority arbitration, stereo Avalon-ST out.
// Define SFX_LOOP_EN to enable the per-slot ctrl register (bit0 loop, bit1 mute right).
module sfx_stream_player #(
    parameter int NUM_SFX       = 4,
    parameter int ADDR_W        = 15,
    parameter int SAMPLE_W      = 16,
    parameter int SAMPLE_PERIOD = 285,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         writedata,
    input  logic                write,
    input  logic                chipselect,
    input  logic [4:0]          address,
    input  logic [NUM_SFX-1:0]  sfx_trig,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_rdata,
    input  logic                L_READY,
    input  logic                R_READY,
    output logic [SAMPLE_W-1:0] L_DATA,
    output logic [SAMPLE_W-1:0] R_DATA,
    output logic                L_VALID,
    output logic                R_VALID,
    output logic                busy,
    output logic [2:0]          active_slot,
    output logic [CNT_W-1:0]    overrun_cnt
);
    // state | meaning: IDLE wait for tick | FETCH rom_addr presented | CAPTURE scaled sample latched
    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_CAPTURE = 2'd2;
    localparam logic [3:0] NUM_SFX_L = 4'(NUM_SFX);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [ADDR_W-1:0]   r_base [NUM_SFX];
    logic [15:0]         r_len  [NUM_SFX];
    logic [3:0]          r_vol  [NUM_SFX];
`ifdef SFX_LOOP_EN
    logic [1:0]          r_ctrl [NUM_SFX];
`endif
    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_tick_cnt, r_overrun;
    logic                r_busy, r_seq_ok;
    logic [2:0]          r_active, r_fetch_slot;
    logic [15:0]         r_idx;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [SAMPLE_W-1:0] r_l_data, r_r_data;
    logic                r_l_valid, r_r_valid;

    logic                w_wr, w_slot_wr, w_trig_wr, w_stop, w_tick;
    logic [NUM_SFX-1:0]  w_req;
    logic                w_req_any, w_req_len_ok, w_accept;
    logic [2:0]          w_req_k;
    logic [ADDR_W-1:0]   w_cur_base;
    logic [15:0]         w_cur_len;
    logic                w_cur_loop, w_cap_mute;
    logic [3:0]          w_cap_vol;
    logic [SAMPLE_W-1:0] w_sample;
    logic                w_load_smp, w_load_sil, w_load, w_pending;

    assign w_wr      = chipselect && write;
    assign w_slot_wr = w_wr && ({1'b0, address[4:2]} < NUM_SFX_L);
    assign w_trig_wr = w_wr && (address == 5'h1F);
    assign w_stop    = w_trig_wr && writedata[15];
    assign w_req     = sfx_trig | (w_trig_wr ? writedata[NUM_SFX-1:0] : '0);
    assign w_tick    = (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_req_any    = 1'b0;
        w_req_k      = '0;
        w_req_len_ok = 1'b0;
        w_cur_base   = '0;
        w_cur_len    = '0;
        w_cur_loop   = 1'b0;
        w_cap_vol    = '0;
        w_cap_mute   = 1'b0;
        for (int s = 0; s < NUM_SFX; s++) begin
            if (w_req[s]) begin
                w_req_any    = 1'b1;
                w_req_k      = 3'(s);
                w_req_len_ok = (r_len[s] != 16'd0);
            end
            if (r_active == 3'(s)) begin
                w_cur_base = r_base[s];
                w_cur_len  = r_len[s];
`ifdef SFX_LOOP_EN
                w_cur_loop = r_ctrl[s][0];
`endif
            end
            if (r_fetch_slot == 3'(s)) begin
                w_cap_vol  = r_vol[s];
`ifdef SFX_LOOP_EN
                w_cap_mute = r_ctrl[s][1];
`endif
            end
        end
    end

    assign w_accept   = w_req_any && w_req_len_ok && !w_stop && (!r_busy || (w_req_k >= r_active));
    assign w_sample   = SAMPLE_W'($signed(rom_rdata) >>> w_cap_vol);
    assign w_load_smp = (r_state == S_CAPTURE);
    assign w_load_sil = (r_state == S_IDLE) && w_tick && !r_busy;
    assign w_load     = w_load_smp || w_load_sil;
    assign w_pending  = (r_l_valid && !L_READY) || (r_r_valid && !R_READY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SFX; s++) begin
                r_base[s] <= '0;
                r_len[s]  <= '0;
                r_vol[s]  <= '0;
`ifdef SFX_LOOP_EN
                r_ctrl[s] <= '0;
`endif
            end
        end else if (w_slot_wr) begin
            for (int s = 0; s < NUM_SFX; s++) begin
                if (address[4:2] == 3'(s)) begin
                    case (address[1:0])
                        2'd0: r_base[s] <= ADDR_W'(writedata);
                        2'd1: r_len[s]  <= writedata;
                        2'd2: r_vol[s]  <= writedata[3:0];
                        default: begin
`ifdef SFX_LOOP_EN
                            r_ctrl[s] <= writedata[1:0];
`endif
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_busy       <= 1'b0;
            r_seq_ok     <= 1'b0;
            r_active     <= '0;
            r_fetch_slot <= '0;
            r_idx        <= '0;
            r_rom_addr   <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_tick && r_busy) begin
                        r_state      <= S_FETCH;
                        r_rom_addr   <= w_cur_base + ADDR_W'(r_idx);
                        r_fetch_slot <= r_active;
                        r_seq_ok     <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_state  <= S_IDLE;
                    r_seq_ok <= 1'b0;
                    // r_seq_ok is cleared by stop/accept so a preempted fetch never advances the new slot
                    if (r_seq_ok) begin
                        if (({1'b0, r_idx} + 17'd1) >= {1'b0, w_cur_len}) begin
                            r_idx <= '0;
                            if (!w_cur_loop) begin
                                r_busy   <= 1'b0;
                                r_active <= '0;
                            end
                        end else begin
                            r_idx <= r_idx + 16'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_stop) begin
                r_busy   <= 1'b0;
                r_active <= '0;
                r_seq_ok <= 1'b0;
            end else if (w_accept) begin
                r_busy   <= 1'b1;
                r_active <= w_req_k;
                r_idx    <= '0;
                r_seq_ok <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_data  <= '0;
            r_r_data  <= '0;
            r_l_valid <= 1'b0;
            r_r_valid <= 1'b0;
            r_overrun <= '0;
        end else if (w_load) begin
            r_l_data  <= w_load_smp ? w_sample : '0;
            r_r_data  <= (w_load_smp && !w_cap_mute) ? w_sample : '0;
            r_l_valid <= 1'b1;
            r_r_valid <= 1'b1;
            if (w_pending && (r_overrun != '1))
                r_overrun <= r_overrun + CNT_W'(1);
        end else begin
            if (r_l_valid && L_READY) r_l_valid <= 1'b0;
            if (r_r_valid && R_READY) r_r_valid <= 1'b0;
        end
    end

    assign rom_addr    = r_rom_addr;
    assign L_DATA      = r_l_data;
    assign R_DATA      = r_r_data;
    assign L_VALID     = r_l_valid;
    assign R_VALID     = r_r_valid;
    assign busy        = r_busy;
    assign active_slot = r_active;
    assign overrun_cnt = r_overrun;
endmodule

// File: tb/tb_sfx_stream_player.sv
// Scoreboard bench for sfx_stream_player: a per-tick reference model pushes expected samples, a monitor pops on handshakes.
module tb_sfx_stream_player;
    localparam int NS = 4, AW = 15, SW = 16, P = 285, CW = 16;

    logic          clk = 1'b0, reset = 1'b1;
    logic [15:0]   writedata = '0;
    logic          write = 1'b0, chipselect = 1'b0;
    logic [4:0]    address = '0;
    logic [NS-1:0] sfx_trig = '0;
    logic [AW-1:0] rom_addr;
    logic [SW-1:0] rom_rdata = '0;
    logic          L_READY = 1'b1, R_READY = 1'b1;
    logic [SW-1:0] L_DATA, R_DATA;
    logic          L_VALID, R_VALID, busy;
    logic [2:0]    active_slot;
    logic [CW-1:0] overrun_cnt;

    always #5 clk = ~clk;

    sfx_stream_player #(.NUM_SFX(NS), .ADDR_W(AW), .SAMPLE_W(SW), .SAMPLE_PERIOD(P), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(chipselect),
        .address(address), .sfx_trig(sfx_trig), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .L_READY(L_READY), .R_READY(R_READY), .L_DATA(L_DATA), .R_DATA(R_DATA),
        .L_VALID(L_VALID), .R_VALID(R_VALID), .busy(busy), .active_slot(active_slot),
        .overrun_cnt(overrun_cnt));

    logic [15:0] rom [0:32767];
    always @(posedge clk) rom_rdata <= rom[rom_addr];

    typedef struct { logic [15:0] d; int unsigned c; } exp_t;
    exp_t q_l[$], q_r[$];
    exp_t el, er;
    int errors = 0, checks = 0;
    int unsigned cyc = 0;
    int m_cnt = 0, m_act = 0, m_idx = 0;
    bit m_busy = 0;
    int m_base [NS], m_len [NS], m_vol [NS];
    bit m_loop [NS], m_mute [NS];
    bit chk_r = 1, chk_lat = 1;
    event tick_ev;
    logic [AW-1:0] ra;
    int op, rs;
    logic [15:0] rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_cnt = 0; m_busy = 0; m_act = 0; m_idx = 0;
        for (int i = 0; i < NS; i++) begin
            m_base[i] = 0; m_len[i] = 0; m_vol[i] = 0; m_loop[i] = 0; m_mute[i] = 0;
        end
        q_l.delete(); q_r.delete();
    endtask

    // One tick of the reference player: emit the next sample of the playing effect, or silence.
    task automatic model_tick();
        logic signed [15:0] s;
        exp_t el_n, er_n;
        if (m_busy) begin
            s = $signed(rom[(m_base[m_act] + m_idx) % 32768]) >>> m_vol[m_act];
            el_n.d = s; er_n.d = m_mute[m_act] ? 16'h0 : s;
            el_n.c = cyc + 2; er_n.c = cyc + 2;
            m_idx++;
            if (m_idx >= m_len[m_act]) begin
                if (m_loop[m_act]) m_idx = 0;
                else begin m_busy = 0; m_act = 0; m_idx = 0; end
            end
        end else begin
            el_n.d = 0; er_n.d = 0; el_n.c = cyc; er_n.c = cyc;
        end
        q_l.push_back(el_n);
        if (chk_r) q_r.push_back(er_n);
    endtask

    task automatic model_trig(input logic [NS-1:0] v, input bit stop);
        int k = -1;
        for (int i = 0; i < NS; i++) if (v[i]) k = i;
        if (stop) begin m_busy = 0; m_act = 0; end
        else if (k >= 0 && m_len[k] != 0 && (!m_busy || k >= m_act)) begin
            m_act = k; m_idx = 0; m_busy = 1;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            cyc++;
            if (m_cnt == P - 1) begin m_cnt = 0; model_tick(); -> tick_ev; end
            else m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (L_VALID && L_READY) begin
                if (q_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL l_extra: got 0x%0h expected no sample", L_DATA);
                end else begin
                    el = q_l.pop_front();
                    chk("l_data", 32'(L_DATA), 32'(el.d));
                    if (chk_lat) chk("l_cycle", cyc, el.c);
                end
            end
            if (chk_r && R_VALID && R_READY) begin
                if (q_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_extra: got 0x%0h expected no sample", R_DATA);
                end else begin
                    er = q_r.pop_front();
                    chk("r_data", 32'(R_DATA), 32'(er.d));
                    if (chk_lat) chk("r_cycle", cyc, er.c);
                end
            end
        end
    end

    // Stimulus only lands well away from the tick and the following fetch/capture cycles.
    task automatic wait_safe();
        @(posedge clk); #2;
        while (m_cnt < 8 || m_cnt > P - 8) begin @(posedge clk); #2; end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [15:0] d);
        wait_safe();
        address = a; writedata = d; chipselect = 1; write = 1;
        @(posedge clk); #2;
        chipselect = 0; write = 0;
        if (a == 5'h1F) model_trig(d[NS-1:0], d[15]);
        else if (a[4:2] < NS) begin
            case (a[1:0])
                2'd0: m_base[a[4:2]] = int'(d[AW-1:0]);
                2'd1: m_len[a[4:2]] = int'(d);
                2'd2: m_vol[a[4:2]] = int'(d[3:0]);
                default: begin
`ifdef SFX_LOOP_EN
                    m_loop[a[4:2]] = d[0]; m_mute[a[4:2]] = d[1];
`endif
                end
            endcase
        end
    endtask

    task automatic pin_trig(input logic [NS-1:0] v);
        wait_safe();
        sfx_trig = v;
        @(posedge clk); #2;
        sfx_trig = '0;
        model_trig(v, 0);
    endtask

    task automatic cfg(input int s, input logic [15:0] base, input logic [15:0] len, input logic [15:0] vol);
        bus_wr(5'(s * 4 + 0), base);
        bus_wr(5'(s * 4 + 1), len);
        bus_wr(5'(s * 4 + 2), vol);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(tick_ev);
    endtask

    task automatic chk_state();
        wait_safe();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("active_slot", 32'(active_slot), 32'(m_act));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
        rom[15'h100] = 16'h4000; rom[15'h101] = 16'h8000; rom[15'h102] = 16'h0010;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_l_data", 32'(L_DATA), 0);
        chk("rst_valid", 32'({L_VALID, R_VALID}), 0);
        chk("rst_busy_act", 32'({busy, active_slot}), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        @(posedge clk); #2; reset = 0;

        // slot 1: three scaled samples then silence
        cfg(1, 16'h0100, 16'd3, 16'd1);
        bus_wr(5'h1F, 16'h0002);
        chk_state();
        wait_ticks(5);
        chk_state();

        // preemption, ignored lower request, stop wins over trigger
        cfg(0, 16'($urandom), 16'd20, 16'd0);
        cfg(3, 16'($urandom), 16'd20, 16'd2);
        cfg(2, 16'($urandom), 16'd5, 16'd0);
        pin_trig(4'b0001);
        wait_ticks(2);
        chk_state();
        pin_trig(4'b1000);
        chk("preempt_act", 32'(active_slot), 3);
        wait_ticks(1);
        bus_wr(5'h1F, 16'h0004);
        chk("lower_ignored", 32'(active_slot), 3);
        wait_ticks(1);
        bus_wr(5'h1F, 16'h8008);
        chk("stop_busy", 32'(busy), 0);
        wait_ticks(2);
        chk_state();

        // asynchronous reset in the middle of playback
        pin_trig(4'b0001);
        wait_safe();
        L_READY = 0;
        wait_ticks(1);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_lvalid", 32'(L_VALID), 1);
        #1; reset = 1;
        #1;
        chk("arst_valid", 32'({L_VALID, R_VALID}), 0);
        chk("arst_busy_act", 32'({busy, active_slot}), 0);
        chk("arst_data", 32'({L_DATA, R_DATA}), 0);
        model_reset();
        L_READY = 1;
        @(posedge clk); @(posedge clk); #2; reset = 0;
        wait_ticks(1);
        @(negedge clk);
        chk("first_tick_cycle", cyc, P);
        chk("first_tick_silence", 32'({L_VALID, L_DATA}), 32'h10000);

        // right sink stalled for three samples
        wait_safe();
        R_READY = 0; chk_r = 0;
        cfg(1, 16'h0100, 16'd3, 16'd1);
        bus_wr(5'h1F, 16'h0002);
        wait_ticks(3);
        repeat (4) @(posedge clk);
        #2;
        chk("overrun_cnt", 32'(overrun_cnt), 2);
        chk("r_valid_held", 32'(R_VALID), 1);
        chk("r_data_newest", 32'(R_DATA), 32'h0008);
        R_READY = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("r_valid_drained", 32'(R_VALID), 0);
        chk_r = 1;
        wait_ticks(1);
        wait_safe();
        chk("overrun_stays", 32'(overrun_cnt), 2);

        // len==0 is refused; base+idx wraps at the top of the ROM
        ra = rom_addr;
        bus_wr(5'h1F, 16'h0004);
        chk_state();
        wait_ticks(1);
        @(negedge clk);
        chk("len0_rom_addr", 32'(rom_addr), 32'(ra));
        cfg(2, 16'h7FFF, 16'd2, 16'd0);
        bus_wr(5'h1F, 16'h0004);
        wait_ticks(1);
        @(negedge clk);
        chk("wrap_addr0", 32'(rom_addr), 32'h7FFF);
        wait_ticks(1);
        @(negedge clk);
        chk("wrap_addr1", 32'(rom_addr), 0);

        // looping two-sample effect (one-shot in the default build)
        cfg(0, 16'($urandom), 16'd2, 16'd0);
        bus_wr(5'h03, 16'h0001);
        pin_trig(4'b0001);
        wait_ticks(6);
        wait_safe();
`ifdef SFX_LOOP_EN
        chk("loop_busy", 32'(busy), 1);
`else
        chk("oneshot_busy", 32'(busy), 0);
`endif
        bus_wr(5'h1F, 16'h8000);
        chk_state();

        // random register traffic, triggers and stops
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            if (op < 2) begin
                rs = $urandom_range(0, 7);
                case ($urandom_range(0, 3))
                    0: rd = 16'($urandom);
                    1: rd = 16'($urandom_range(0, 6));
                    2: rd = 16'($urandom_range(0, 15));
                    default: rd = 16'($urandom_range(0, 3));
                endcase
                bus_wr(5'($urandom_range(0, 31)), rd);
            end else if (op == 2) begin
                pin_trig(NS'($urandom));
            end else begin
                rd = 16'($urandom) & 16'h000F;
                if ($urandom_range(0, 7) == 0) rd[15] = 1'b1;
                bus_wr(5'h1F, rd);
            end
            if ($urandom_range(0, 1) == 1) wait_ticks(1);
            chk_state();
        end
        wait_ticks(2);
        wait_safe();
        chk("l_queue_drained", 32'(q_l.size()), 0);
        chk("r_queue_drained", 32'(q_r.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sfx_stream_player.md
Name: sfx_stream_player

Overview:
- Parametrised multi-slot sound-effect sequencer. Generalises the fixed two-effect pellet/game-over player to NUM_SFX software-configurable slots.
- Fetches samples from an external shared sample ROM at a programmable rate, applies per-slot volume, arbitrates by priority, and streams to the audio codec over Avalon-ST left/right channels.
- Uses a proper VALID/READY hold handshake.
- Sits beside the display controller on the same Avalon-MM slave bus.

Parameters:
- NUM_SFX, 4, number of effect slots (1..7).
- ADDR_W, 15, sample ROM address width.
- SAMPLE_W, 16, sample and output width.
- SAMPLE_PERIOD, 285, clk cycles per output sample (>=4).
- CNT_W, 16, width of the tick counter and the overrun counter.

Ports:
- clk in 1: system clock (50 MHz).
- reset in 1: asynchronous, active-high reset.
- writedata in 16: bus write data.
- write in 1: bus write strobe.
- chipselect in 1: bus select.
- address in 5: register address.
- sfx_trig in NUM_SFX: hardware trigger pulses, one bit per slot.
- rom_addr out ADDR_W: sample ROM read address.
- rom_rdata in SAMPLE_W: ROM data, valid exactly 1 cycle after rom_addr.
- L_READY in 1: left sink ready.
- R_READY in 1: right sink ready.
- L_DATA out SAMPLE_W: left sample.
- R_DATA out SAMPLE_W: right sample.
- L_VALID out 1: left sample valid.
- R_VALID out 1: right sample valid.
- busy out 1: a slot is playing.
- active_slot out 3: index of the playing slot (0 when idle).
- overrun_cnt out CNT_W: count of samples not consumed before the next tick; saturates.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high. On reset:
  - all outputs are 0;
  - all slot registers are 0;
  - the FSM is in IDLE and the tick counter is 0.
- Register map (write-only; write = chipselect && write):
  - address {slot[2:0], fld[1:0]} with slot < NUM_SFX selects a slot register:
    - fld 0: base[ADDR_W-1:0];
    - fld 1: len[15:0] in samples;
    - fld 2: vol_shift[3:0], arithmetic right shift applied to each sample;
    - fld 3: ctrl (see Optional Feature).
  - 0x1F: writedata[NUM_SFX-1:0] are trigger bits; writedata[15]=1 stops playback immediately. Stop wins over triggers in the same write.
  - Writes to unmapped addresses are ignored.
- Tick: the counter runs 0..SAMPLE_PERIOD-1, then wraps. The tick pulse is asserted on the cycle the counter equals SAMPLE_PERIOD-1.
- Trigger arbitration (each cycle):
  - The request vector is the OR of sfx_trig and the bus trigger bits. The highest set index k wins.
  - k is accepted if idle, or if k >= active_slot. Equal k restarts the effect from sample 0.
  - Otherwise the request is dropped; requests are not queued.
  - A slot with len==0 is never accepted.
  - On accept: active_slot<=k, sample index<=0, busy<=1, effective the next cycle.
- FSM states:
  - IDLE: on tick, load a silence sample (0) into the output stage.
  - FETCH: entered on tick while busy; drives rom_addr = base + idx, modulo 2^ADDR_W (wraps).
  - CAPTURE: one cycle later, latches rom_rdata >>> vol_shift.
    - idx increments.
    - If idx == len-1: busy<=0 and active_slot<=0 (non-loop case).
  - Return to IDLE after CAPTURE.
  - Latency: tick to VALID = 2 cycles.
  - Slot register writes during playback take effect on the next fetch.
- Output stage:
  - L_DATA and R_DATA are loaded with the same sample; L_VALID and R_VALID are set to 1.
  - Each channel independently clears its VALID on a cycle where VALID && READY.
  - DATA is held while VALID is high.
  - If a new sample is loaded while either VALID is still high: overrun_cnt increments by 1 (saturating); both channels take the new data; VALID stays 1.
- Preemption mid-fetch: a trigger accepted during FETCH or CAPTURE does not cancel the in-flight sample. The new slot starts on the next tick.
- Stop: busy<=0 immediately; an in-flight CAPTURE still outputs its sample.

Optional Feature:
- Macro: SFX_LOOP_EN.
- When defined:
  - ctrl[0] is the per-slot loop bit.
  - At the end of a looping slot, idx wraps to 0 and busy stays 1 until stop or preemption.
  - ctrl[1] selects "mute right": R_DATA is forced to 0 (VALID still asserted).
- When undefined: ctrl writes are ignored, and all slots are one-shot and stereo-identical.

Test Plan:
- Reset mid-playback (busy=1, L_VALID=1), assert reset async -> all outputs 0 in the same cycle; after release, the first tick (cycle 285) outputs silence with L_VALID=1.
- Slot 1: base=0x100, len=3, vol=1, ROM[0x100..0x102]=0x4000, 0x8000, 0x0010; trigger via 0x1F=0x0002; READY held 1 -> samples 0x2000, 0xC000, 0x0008 on consecutive ticks, 2 cycles after each tick; busy drops after the third; the following samples are 0.
- Slot 0 playing, then sfx_trig=0b1000 -> active_slot=3 from the next tick. Then trigger slot 2 -> ignored. Then a bus write with bit15 plus bit3 -> stopped, busy=0.
- L_READY=1, R_READY=0 for 3 ticks -> L_VALID pulses 1 cycle per sample; R_VALID stays 1; overrun_cnt=2; R_DATA equals the newest sample.
- Slot with len=0 triggered -> busy stays 0, rom_addr unchanged; base=0x7FFF, len=2 -> rom_addr 0x7FFF then 0x0000.
- SFX_LOOP_EN: slot 0 len=2 loop=1 -> sample sequence A, B, A, B... for 6 ticks with busy=1; with the macro undefined -> A, B, 0, 0.
